// File: rtl/matvec_pkg.sv
// Shared sizing for the matrix-vector multiplier and its output stage.
package matvec_pkg;

    function automatic int unsigned tree_depth(input int unsigned c);
        return $clog2(c);
    endfunction

    // Launch register plus one register per adder-tree level.
    function automatic int unsigned latency(input int unsigned c);
        return tree_depth(c) + 1;
    endfunction

    localparam int unsigned R_DEF   = 2;
    localparam int unsigned C_DEF   = 2;
    localparam int unsigned W_X_DEF = 3;
    localparam int unsigned W_K_DEF = 3;
    localparam int unsigned W_Y_DEF = W_X_DEF + W_K_DEF + tree_depth(C_DEF);

endpackage

// File: rtl/matvec_vec_fifo.sv
// Two-entry result-vector buffer; push while full is legal only alongside a pop.
module matvec_vec_fifo #(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);

endmodule

// File: rtl/matvec_out_serializer.sv
// Tracks operands in flight through the multiplier, buffers finished y vectors
// and streams them element by element; backpressure stalls the multiplier via cen.
module matvec_out_serializer
    import matvec_pkg::*;
#(
    parameter int unsigned R   = R_DEF,
    parameter int unsigned C   = C_DEF,
    parameter int unsigned W_Y = W_Y_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             cen,
    input  logic [R*W_Y-1:0] y,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W_Y-1:0]   m_data,
    output logic             m_last
);
    localparam int unsigned LATENCY = latency(C);
    localparam int unsigned IDX_W   = (R > 1) ? $clog2(R) : 1;

    logic [LATENCY-1:0] r_vld;
    logic [IDX_W-1:0]   r_idx;
    logic [LATENCY:0]   w_vld_in;
    logic [R*W_Y-1:0]   w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_beat;
    logic               w_pop_last;
    logic               w_push;

    assign w_vld_in   = {r_vld, s_valid};
    assign w_beat     = m_valid && m_ready;
    assign m_valid    = !w_empty;
    assign m_last     = (r_idx == IDX_W'(R - 1));
    assign w_pop_last = w_beat && m_last;
    // Freeing a slot this cycle lets the waiting tail result in, so m_ready reaches cen.
    assign cen        = !(r_vld[LATENCY-1] && w_full && !w_pop_last);
    assign s_ready    = cen;
    assign w_push     = r_vld[LATENCY-1] && cen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else if (cen) begin
            r_vld <= w_vld_in[LATENCY-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_beat) begin
            r_idx <= m_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    always_comb begin
        m_data = '0;
        for (int unsigned r = 0; r < R; r++) begin
            if (r_idx == IDX_W'(r)) begin
                m_data = w_head[r*W_Y +: W_Y];
            end
        end
    end

    matvec_vec_fifo #(
        .WIDTH(R * W_Y)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (w_push),
        .pop  (w_pop_last),
        .din  (y),
        .dout (w_head),
        .full (w_full),
        .empty(w_empty)
    );

endmodule

// File: tb/tb_matvec_out_serializer.sv
// Directed bench for matvec_out_serializer with a stand-in multiplier pipeline and a vector scoreboard.
module tb_matvec_out_serializer;
    localparam int R   = 2;
    localparam int C   = 2;
    localparam int W_Y = 7;
    localparam int LAT = $clog2(C) + 1;

    typedef logic [R*W_Y-1:0] vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic           cen;
    vec_t           y;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [W_Y-1:0] m_data;
    logic           m_last;

    vec_t x_vec = '0;
    vec_t pipe [LAT];
    vec_t sb [$];
    int   m_idx = 0;
    bit   armed = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    matvec_out_serializer #(.R(R), .C(C), .W_Y(W_Y)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .cen    (cen),
        .y      (y),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_last (m_last)
    );

    // Stand-in multiplier: launched operand vector appears on y LAT enabled edges later.
    always @(posedge clk) begin
        if (cen) begin
            pipe[0] <= s_valid ? x_vec : vec_t'({$urandom, $urandom});
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign y = pipe[LAT-1];

    function automatic vec_t mk(input int a, input int b);
        vec_t v;
        v[W_Y-1:0]     = a[W_Y-1:0];
        v[2*W_Y-1:W_Y] = b[W_Y-1:0];
        return v;
    endfunction

    function automatic int elem(input vec_t v, input int r);
        logic signed [W_Y-1:0] e;
        e = v[r*W_Y +: W_Y];
        return int'(e);
    endfunction

    function automatic int sdata();
        logic signed [W_Y-1:0] e;
        e = m_data;
        return int'(e);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Drive one cycle's inputs just after the edge, return at that cycle's negedge.
    task automatic step(input logic sv, input vec_t xv, input logic mr, input logic rs);
        @(posedge clk);
        #1;
        s_valid = sv;
        x_vec   = xv;
        m_ready = mr;
        rst     = rs;
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60 && (sb.size() != 0 || m_valid); i++) step(1'b0, '0, 1'b1, 1'b0);
        chk({nm, "_left_in_scoreboard"}, sb.size(), 0);
        chk({nm, "_m_valid_after_drain"}, int'(m_valid), 0);
    endtask

    // Scoreboard: accepted vectors must come out whole, in order, one element per beat.
    always @(negedge clk) begin
        if (armed) begin
            if (m_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_beat", 1, 0);
                end else begin
                    chk("sb_data", sdata(), elem(sb[0], m_idx));
                    chk("sb_last", int'(m_last), int'(m_idx == R - 1));
                end
            end
            if (!cen) begin
                chk("stall_needs_buffered_data", int'(m_valid), 1);
                chk("stall_while_pop_last", int'(m_ready && m_last), 0);
            end
            chk("s_ready_eq_cen", int'(s_ready), int'(cen));
            if (rst) begin
                sb.delete();
                m_idx = 0;
            end else begin
                if (m_valid && m_ready && sb.size() != 0) begin
                    if (m_idx == R - 1) begin
                        void'(sb.pop_front());
                        m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
                if (s_valid && cen) sb.push_back(x_vec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ev [5] = '{0, 0, 1, 1, 0};
        int ed [5] = '{0, 0, -5, 12, 0};
        int el [5] = '{0, 0, 0, 1, 0};
        int qv [7] = '{1, 1, 1, 1, 1, 1, 0};
        int qd [7] = '{-3, 7, 20, -20, 1, -1, 0};
        int ql [7] = '{0, 1, 0, 1, 0, 1, 0};
        int qc [2] = '{0, 1};
        int accepted;
        int stalls;
        int k;

        // Reset
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        armed = 1'b1;

        // Single vector {-5, 12}, launched in cycle 0
        step(1'b1, mk(-5, 12), 1'b1, 1'b0);
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_cen", int'(cen), 1);
        chk("reset_s_ready", int'(s_ready), 1);
        chk("reset_m_last", int'(m_last), 0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("single_valid_c%0d", c + 1), int'(m_valid), ev[c]);
            if (ev[c] != 0) begin
                chk($sformatf("single_data_c%0d", c + 1), sdata(), ed[c]);
                chk($sformatf("single_last_c%0d", c + 1), int'(m_last), el[c]);
            end
        end

        // Back-to-back: s_valid held 6 cycles, vector advances only when accepted
        accepted = 0;
        stalls = 0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, mk(10 + k, -10 - k), 1'b1, 1'b0);
            if (cen) begin
                accepted++;
                k++;
            end else begin
                stalls++;
            end
        end
        chk("b2b_accepted", accepted, 5);
        chk("b2b_stall_cycles", stalls, 1);
        drain("b2b");

        // Backpressure: three launches with m_ready low
        step(1'b1, mk(-3, 7), 1'b0, 1'b0);
        step(1'b1, mk(20, -20), 1'b0, 1'b0);
        step(1'b1, mk(1, -1), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("bp_cen_before_full", int'(cen), 1);
        for (int c = 0; c < 15; c++) begin
            step(1'b1, mk(33, 33), 1'b0, 1'b0);
            chk("bp_cen_stalled", int'(cen), 0);
            chk("bp_data_stable", sdata(), -3);
            chk("bp_last_stable", int'(m_last), 0);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        chk("bp_cen_stalled_end", int'(cen), 0);
        for (int c = 0; c < 7; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("bp_drain_valid_%0d", c), int'(m_valid), qv[c]);
            if (qv[c] != 0) begin
                chk($sformatf("bp_drain_data_%0d", c), sdata(), qd[c]);
                chk($sformatf("bp_drain_last_%0d", c), int'(m_last), ql[c]);
            end
            // Cycle 1 pops the last beat of a full buffer while the tail result waits
            if (c < 2) chk($sformatf("pop_last_push_cen_%0d", c), int'(cen), qc[c]);
        end
        drain("bp");

        // Reset mid-stream: buffer holds two vectors, vld all ones
        step(1'b1, mk(2, 3), 1'b0, 1'b0);
        step(1'b1, mk(4, 5), 1'b0, 1'b0);
        step(1'b1, mk(6, 7), 1'b0, 1'b0);
        step(1'b1, mk(8, 9), 1'b0, 1'b0);
        chk("rst_setup_cen", int'(cen), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("rst_setup_full_stall", int'(cen), 0);
        chk("rst_setup_m_valid", int'(m_valid), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("rst_after_m_valid", int'(m_valid), 0);
        chk("rst_after_cen", int'(cen), 1);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("rst_idle_m_valid", int'(m_valid), 0);
        end
        step(1'b1, mk(9, -9), 1'b1, 1'b0);
        for (int c = 1; c <= LAT + 2; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("rst_relaunch_valid_c%0d", c), int'(m_valid), int'(c >= LAT + 1));
            if (c == LAT + 1) chk("rst_relaunch_first_data", sdata(), 9);
            if (c == LAT + 2) chk("rst_relaunch_second_data", sdata(), -9);
        end
        drain("rst");

        // Extremes: -64 and +63 pass bit-exact
        step(1'b1, mk(-64, 63), 1'b1, 1'b0);
        for (int c = 1; c <= LAT + 2; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (c == LAT + 1) chk("extreme_neg_bits", int'(m_data), 64);
            if (c == LAT + 2) chk("extreme_pos_bits", int'(m_data), 63);
        end
        drain("extreme");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
